// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: per-key FSM state encoding and default counter width.
// The KEY_LONG_EN macro selects whether the long-press logic is built.
package key_pkg;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_DB   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] RELEASE_DB = 2'd3;

  localparam int KEY_CNT_W = 26;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, debounce counter and (with KEY_LONG_EN) hold counter.
// All outputs are registered. Pulses are one cycle wide.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 50,
  parameter int LONG_CYC     = 500,
  parameter int CNT_W        = KEY_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  // Reject parameter sets the counters cannot honour.
  if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC ||
      longint'(LONG_CYC) > (longint'(1) << CNT_W)) begin : g_param_check
    $error("key_debounce_ch: invalid DEBOUNCE_CYC/LONG_CYC/CNT_W");
  end

  logic             sync1_r, sync2_r;
  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] dcnt_r, dcnt_s;
  logic             level_r, level_s;
  logic             press_r, press_s;
  logic             release_r, release_s;
  logic             long_r, long_s;
`ifdef KEY_LONG_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  logic [CNT_W-1:0] lcnt_r, lcnt_s;
  logic             long_done_r, long_done_s;
`endif

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
    end
  end

  // Next-state and pulse logic; sync2_r is 0 while the key is pressed.
  always_comb begin
    state_s   = state_r;
    dcnt_s    = dcnt_r;
    level_s   = level_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    long_s    = 1'b0;
`ifdef KEY_LONG_EN
    lcnt_s      = lcnt_r;
    long_done_s = long_done_r;
`endif
    case (state_r)
      IDLE: begin
        if (!sync2_r) begin
          state_s = PRESS_DB;
          dcnt_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      PRESS_DB: begin
        if (sync2_r) begin
          state_s = IDLE;
        end else if (dcnt_r == DB_LAST) begin
          state_s = HELD;
          press_s = 1'b1;
          level_s = 1'b1;
`ifdef KEY_LONG_EN
          lcnt_s      = '0;
          long_done_s = 1'b0;
`endif
        end else begin
          dcnt_s = dcnt_r + CNT_W'(1);
        end
      end
      HELD: begin
        if (sync2_r) begin
          state_s = RELEASE_DB;
          dcnt_s  = '0;
        end else begin
`ifdef KEY_LONG_EN
          // lcnt saturates; long_done keeps the pulse to one per hold, even across release bounces.
          if (lcnt_r != LONG_LAST) begin
            lcnt_s = lcnt_r + CNT_W'(1);
          end else if (!long_done_r) begin
            long_s      = 1'b1;
            long_done_s = 1'b1;
          end else begin
            long_done_s = 1'b1;
          end
`else
          state_s = HELD;
`endif
        end
      end
      RELEASE_DB: begin
        if (!sync2_r) begin
          state_s = HELD;
          dcnt_s  = '0;
        end else if (dcnt_r == DB_LAST) begin
          state_s   = IDLE;
          release_s = 1'b1;
          level_s   = 1'b0;
`ifdef KEY_LONG_EN
          long_done_s = 1'b0;
`endif
        end else begin
          dcnt_s = dcnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        dcnt_s  = '0;
      end
    endcase
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      dcnt_r    <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
`ifdef KEY_LONG_EN
      lcnt_r      <= '0;
      long_done_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      dcnt_r    <= dcnt_s;
      level_r   <= level_s;
      press_r   <= press_s;
      release_r <= release_s;
      long_r    <= long_s;
`ifdef KEY_LONG_EN
      lcnt_r      <= lcnt_s;
      long_done_r <= long_done_s;
`endif
    end
  end

  assign key_level   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;
  assign key_long    = long_r;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for KEY_W active-low push buttons: clean level plus press, release and long-press pulses.
// Define KEY_LONG_EN to build the long-press detector; otherwise key_long is constant 0.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_W        = 4,
  parameter int DEBOUNCE_CYC = 50,
  parameter int LONG_CYC     = 500,
  parameter int CNT_W        = KEY_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_raw    (key_in[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: expected pulses are queued per cycle when keys change
// and popped every cycle; cycles without a queued entry expect no pulse.
module tb_key_debounce;

  localparam int DB   = 50;
  localparam int LONG = 500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_long;

  key_debounce #(.KEY_W(4), .DEBOUNCE_CYC(DB), .LONG_CYC(LONG), .CNT_W(26)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_level = 4'h0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
`ifdef KEY_LONG_EN
  localparam logic LONG_ON = 1'b1;
`else
  localparam logic LONG_ON = 1'b0;
`endif

  // Key changes made before the next edge are first sampled on edge cyc+1.
  function automatic int first_edge();
    return cyc + 1;
  endfunction

  function automatic void push_exp(int c, logic [3:0] p, logic [3:0] r, logic [3:0] l);
    int   idx;
    bit   merged;
    exp_t e;
    idx = sb.size();
    merged = 1'b0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == c) begin
        sb[k].press |= p;
        sb[k].rel   |= r;
        sb[k].lng   |= l;
        merged = 1'b1;
      end else if (sb[k].cyc > c) begin
        idx = k;
      end
    end
    if (!merged) begin
      e.cyc = c; e.press = p; e.rel = r; e.lng = l;
      sb.insert(idx, e);
    end
  endfunction

  function automatic exp_t pop_exp(int c);
    exp_t e;
    e.cyc = c; e.press = 4'h0; e.rel = 4'h0; e.lng = 4'h0;
    while (sb.size() > 0 && sb[0].cyc < c) void'(sb.pop_front());
    if (sb.size() > 0 && sb[0].cyc == c) e = sb.pop_front();
    exp_level = (exp_level | e.press) & ~e.rel;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n  = 1'b0;
    key_in = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rst_n = 1'b1;
      tick();
      e = pop_exp(cyc);
      if ({key_level, key_press, key_release, key_long} !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h want=0000", cyc,
                 {key_level, key_press, key_release, key_long});
      end
      n_cmp++;
    end
  endtask

  task automatic test_clean_press();
    exp_t e;
    for (int i = 0; i < 180; i++) begin
      if (i == 0)   begin key_in[0] = 1'b0; push_exp(first_edge() + DB + 2, 4'b0001, 4'b0, 4'b0); end
      if (i == 100) begin key_in[0] = 1'b1; push_exp(first_edge() + DB + 2, 4'b0, 4'b0001, 4'b0); end
      tick();
      e = pop_exp(cyc);
      if ({key_level, key_press, key_release, key_long} !== {exp_level, e.press, e.rel, e.lng}) begin
        n_fail++;
        $display("FAIL clean_press cyc=%0d got=%h want=%h", cyc,
                 {key_level, key_press, key_release, key_long}, {exp_level, e.press, e.rel, e.lng});
      end
      n_cmp++;
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    for (int i = 0; i < 130; i++) begin
      if (i == 0)  key_in[1] = 1'b0;
      if (i == 30) key_in[1] = 1'b1;
      if (i == 35) key_in[1] = 1'b0;
      if (i == 65) key_in[1] = 1'b1;
      tick();
      e = pop_exp(cyc);
      if ({key_level, key_press, key_release, key_long} !== {exp_level, e.press, e.rel, e.lng}) begin
        n_fail++;
        $display("FAIL bounce cyc=%0d got=%h want=%h", cyc,
                 {key_level, key_press, key_release, key_long}, {exp_level, e.press, e.rel, e.lng});
      end
      n_cmp++;
    end
  endtask

  task automatic test_release_bounce();
    exp_t e;
    for (int i = 0; i < 150; i++) begin
      if (i == 0)  begin key_in[2] = 1'b0; push_exp(first_edge() + DB + 2, 4'b0100, 4'b0, 4'b0); end
      if (i == 70) key_in[2] = 1'b1;
      if (i == 80) key_in[2] = 1'b0;
      if (i == 83) begin key_in[2] = 1'b1; push_exp(first_edge() + DB + 2, 4'b0, 4'b0100, 4'b0); end
      tick();
      e = pop_exp(cyc);
      if ({key_level, key_press, key_release, key_long} !== {exp_level, e.press, e.rel, e.lng}) begin
        n_fail++;
        $display("FAIL release_bounce cyc=%0d got=%h want=%h", cyc,
                 {key_level, key_press, key_release, key_long}, {exp_level, e.press, e.rel, e.lng});
      end
      n_cmp++;
    end
  endtask

  task automatic test_long_press();
    exp_t e;
    int   c0;
    for (int i = 0; i < 760; i++) begin
      if (i == 0) begin
        key_in[3] = 1'b0;
        c0 = first_edge();
        push_exp(c0 + DB + 2, 4'b1000, 4'b0, 4'b0);
        if (LONG_ON) push_exp(c0 + DB + 2 + LONG, 4'b0, 4'b0, 4'b1000);
      end
      if (i == 700) begin key_in[3] = 1'b1; push_exp(first_edge() + DB + 2, 4'b0, 4'b1000, 4'b0); end
      tick();
      e = pop_exp(cyc);
      if ({key_level, key_press, key_release, key_long} !== {exp_level, e.press, e.rel, e.lng}) begin
        n_fail++;
        $display("FAIL long_press cyc=%0d got=%h want=%h", cyc,
                 {key_level, key_press, key_release, key_long}, {exp_level, e.press, e.rel, e.lng});
      end
      n_cmp++;
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    for (int i = 0; i < 120; i++) begin
      if (i == 0)  begin key_in = 4'b0000; push_exp(first_edge() + DB + 2, 4'b1111, 4'b0, 4'b0); end
      if (i == 60) begin key_in = 4'b1111; push_exp(first_edge() + DB + 2, 4'b0, 4'b1111, 4'b0); end
      tick();
      e = pop_exp(cyc);
      if ({key_level, key_press, key_release, key_long} !== {exp_level, e.press, e.rel, e.lng}) begin
        n_fail++;
        $display("FAIL simultaneous cyc=%0d got=%h want=%h", cyc,
                 {key_level, key_press, key_release, key_long}, {exp_level, e.press, e.rel, e.lng});
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    for (int i = 0; i < 360; i++) begin
      if (i == 0)   begin key_in[0] = 1'b0; push_exp(first_edge() + DB + 2, 4'b0001, 4'b0, 4'b0); end
      if (i == 200) begin rst_n = 1'b0; exp_level = 4'h0; end
      if (i == 202) begin rst_n = 1'b1; push_exp(first_edge() + DB + 2, 4'b0001, 4'b0, 4'b0); end
      if (i == 300) begin key_in[0] = 1'b1; push_exp(first_edge() + DB + 2, 4'b0, 4'b0001, 4'b0); end
      tick();
      e = pop_exp(cyc);
      if ({key_level, key_press, key_release, key_long} !== {exp_level, e.press, e.rel, e.lng}) begin
        n_fail++;
        $display("FAIL reset_mid_hold cyc=%0d got=%h want=%h", cyc,
                 {key_level, key_press, key_release, key_long}, {exp_level, e.press, e.rel, e.lng});
      end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_hold();
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    n_cmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
